// File: rtl/pri_enc_pkg.sv
// Shared definitions for the registered priority request encoder.
// Build option: define ROUND_ROBIN_EN to select rotating priority in pri_req_encoder.
package pri_enc_pkg;

    localparam int N_REQ_DEF  = 16;
    localparam int OVF_W_DEF  = 8;
    localparam int IDX_W_DEF  = $clog2(N_REQ_DEF);
    localparam int MAX_REQ    = 64;
    localparam int MAX_IDX_W  = 6;

    // Index type at the default request count.
    typedef logic [IDX_W_DEF-1:0] idx_t;

    // One-hot of an index at the widest supported request count; callers truncate.
    function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
        onehot = MAX_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/pri_find_first.sv
// Combinational rotating search: starting at i_start (inclusive) and walking
// downward with wraparound, report the first set bit of i_vec.
// A start of N-1 gives plain highest-index priority.
module pri_find_first #(
    parameter int N = 16,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] i_vec,
    input  logic [W-1:0] i_start,
    output logic         o_found,
    output logic [W-1:0] o_idx
);

    // Sum width covers start + position + 1, at most 2N-1.
    localparam int SW = W + 2;

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [W-1:0]   w_pos;
    logic [SW-1:0]  w_sum;

    assign w_dbl = {i_vec, i_vec};

    // Rotate so that bit i_start lands on the MSB: w_rot[j] = i_vec[(start+1+j) mod N].
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            assign w_rot[gi] = w_dbl[SW'(gi) + SW'(i_start) + SW'(1)];
        end
    endgenerate

    // Highest set bit of the rotated vector is the first hit in search order.
    always_comb begin
        w_pos = '0;
        for (int j = 0; j < N; j++) begin
            if (w_rot[j]) begin
                w_pos = W'(j);
            end
        end
    end

    // Undo the rotation.
    assign w_sum   = SW'(i_start) + SW'(w_pos) + SW'(1);
    assign o_idx   = (w_sum >= SW'(N)) ? W'(w_sum - SW'(N)) : W'(w_sum);
    assign o_found = |i_vec;

endmodule

// File: rtl/pri_req_encoder.sv
// Registered priority request encoder: sticky pending bits, masked selection,
// valid/ready issue stage and a saturating overflow counter.
// Build option: ROUND_ROBIN_EN selects a rotating pointer; undefined gives
// fixed highest-index priority with no pointer register.
module pri_req_encoder
    import pri_enc_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDX_W = $clog2(N_REQ),
    parameter int OVF_W = OVF_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic [N_REQ-1:0] mask_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             any_o,
    output logic             none_o,
    output logic [N_REQ-1:0] pend_o,
    output logic [OVF_W-1:0] ovf_cnt_o
);

    logic [N_REQ-1:0] r_pend;
    logic [IDX_W-1:0] r_idx;
    logic             r_valid;
    logic [OVF_W-1:0] r_ovf;

    logic [N_REQ-1:0] w_avail;
    logic [N_REQ-1:0] w_clr;
    logic [N_REQ-1:0] w_pend_next;
    logic [IDX_W-1:0] w_sel;
    logic [IDX_W-1:0] w_start;
    logic             w_found;
    logic             w_slot_free;
    logic             w_load;
    logic             w_ovf_hit;

    assign w_avail     = r_pend & ~mask_i;
    assign w_slot_free = ~r_valid | ready_i;
    assign w_load      = en_i & w_slot_free & w_found;
    assign w_clr       = w_load ? N_REQ'(onehot(MAX_IDX_W'(w_sel))) : '0;
    // A new request on the bit being issued re-arms it: set wins over clear.
    assign w_pend_next = (r_pend & ~w_clr) | req_i;
    assign w_ovf_hit   = |(req_i & r_pend & ~w_clr);

`ifdef ROUND_ROBIN_EN
    // r_ptr holds the first index to examine: one below the last issued
    // index, so the last winner drops to lowest priority. Reset value N-1
    // makes the first grant identical to fixed priority.
    logic [IDX_W-1:0] r_ptr;

    // Advance the search start past each issued index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= IDX_W'(N_REQ - 1);
        end else if (w_load) begin
            r_ptr <= (w_sel == '0) ? IDX_W'(N_REQ - 1) : (w_sel - IDX_W'(1));
        end
    end

    assign w_start = r_ptr;
`else
    assign w_start = IDX_W'(N_REQ - 1);
`endif

    pri_find_first #(
        .N (N_REQ),
        .W (IDX_W)
    ) u_find (
        .i_vec   (w_avail),
        .i_start (w_start),
        .o_found (w_found),
        .o_idx   (w_sel)
    );

    // Pending capture and saturating overflow count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
            r_ovf  <= '0;
        end else begin
            r_pend <= w_pend_next;
            if (w_ovf_hit && (r_ovf != {OVF_W{1'b1}})) begin
                r_ovf <= r_ovf + OVF_W'(1);
            end
        end
    end

    // Issue stage: load when the slot is free, otherwise drop valid once accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_idx   <= w_sel;
            r_valid <= 1'b1;
        end else if (w_slot_free) begin
            r_valid <= 1'b0;
        end
    end

    assign idx_o     = r_idx;
    assign valid_o   = r_valid;
    assign any_o     = w_found;
    assign none_o    = ~w_found;
    assign pend_o    = r_pend;
    assign ovf_cnt_o = r_ovf;

endmodule

// File: tb/tb_pri_req_encoder.sv
// Self-checking bench for pri_req_encoder (N_REQ=16, OVF_W=8): directed
// table, hand sequences and randomized traffic against a behavioural model.
// Honours ROUND_ROBIN_EN the same way as the design.
module tb_pri_req_encoder;
    import pri_enc_pkg::*;

    localparam int N  = 16;
    localparam int OW = 8;

    logic         clk     = 1'b0;
    logic         rst_n   = 1'b0;
    logic         en_i    = 1'b1;
    logic         ready_i = 1'b1;
    logic [N-1:0] req_i   = '0;
    logic [N-1:0] mask_i  = '0;
    logic [3:0]   idx_o;
    logic         valid_o;
    logic         any_o;
    logic         none_o;
    logic [N-1:0] pend_o;
    logic [OW-1:0] ovf_cnt_o;

    pri_req_encoder #(
        .N_REQ (N),
        .OVF_W (OW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (en_i),
        .req_i     (req_i),
        .mask_i    (mask_i),
        .idx_o     (idx_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .any_o     (any_o),
        .none_o    (none_o),
        .pend_o    (pend_o),
        .ovf_cnt_o (ovf_cnt_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    bit m_pend [N];
    bit m_valid;
    int m_idx;
    int m_ovf;
    int m_last;   // last issued index; 0 at reset so the first search runs 15..0

    task automatic model_reset();
        for (int k = 0; k < N; k++) m_pend[k] = 1'b0;
        m_valid = 1'b0;
        m_idx   = 0;
        m_ovf   = 0;
        m_last  = 0;
    endtask

    function automatic bit model_any();
        for (int k = 0; k < N; k++)
            if (m_pend[k] && !mask_i[k]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int model_pick();
`ifdef ROUND_ROBIN_EN
        for (int d = 1; d <= N; d++) begin
            int k;
            k = (m_last - d + N) % N;
            if (m_pend[k] && !mask_i[k]) return k;
        end
`else
        for (int k = N - 1; k >= 0; k--)
            if (m_pend[k] && !mask_i[k]) return k;
`endif
        return -1;
    endfunction

    function automatic logic [N-1:0] model_pend_vec();
        logic [N-1:0] v;
        for (int k = 0; k < N; k++) v[k] = m_pend[k];
        return v;
    endfunction

    // One clock edge of the intended behaviour, using the inputs held across it.
    task automatic model_step();
        int  sel;
        bit  slot_free;
        bit  load;
        bit  hit;
        slot_free = !m_valid || ready_i;
        sel       = model_pick();
        load      = en_i && slot_free && (sel >= 0);
        if (!load) sel = -1;
        hit = 1'b0;
        for (int k = 0; k < N; k++)
            if (req_i[k] && m_pend[k] && (k != sel)) hit = 1'b1;
        if (hit && m_ovf < (1 << OW) - 1) m_ovf++;
        for (int k = 0; k < N; k++)
            m_pend[k] = (m_pend[k] && (k != sel)) || req_i[k];
        if (load) begin
            m_valid = 1'b1;
            m_idx   = sel;
            m_last  = sel;
        end else if (slot_free) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic compare(input string tag);
        bit a;
        a = model_any();
        check({tag, ".pend"},  64'(pend_o),    64'(model_pend_vec()));
        check({tag, ".valid"}, 64'(valid_o),   64'(m_valid));
        check({tag, ".idx"},   64'(idx_o),     64'(m_idx));
        check({tag, ".any"},   64'(any_o),     64'(a));
        check({tag, ".none"},  64'(none_o),    64'(!a));
        check({tag, ".ovf"},   64'(ovf_cnt_o), 64'(m_ovf));
    endtask

    // Called at a falling edge: drive, clock, advance model, compare at the next falling edge.
    task automatic apply(input logic [N-1:0] req, input logic [N-1:0] mask,
                         input logic en, input logic rdy);
        req_i   = req;
        mask_i  = mask;
        en_i    = en;
        ready_i = rdy;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare("model");
    endtask

    // Asynchronous reset pulse from a falling edge; outputs must clear at once.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_now.valid", 64'(valid_o),   64'(0));
        check("rst_now.pend",  64'(pend_o),    64'(0));
        check("rst_now.idx",   64'(idx_o),     64'(0));
        check("rst_now.ovf",   64'(ovf_cnt_o), 64'(0));
        compare("rst_now");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct packed {
        logic [N-1:0] req;
        logic [N-1:0] mask;
        logic         en;
        logic         rdy;
        logic         exp_valid;
        logic [3:0]   exp_idx;
        logic [N-1:0] exp_pend;
        logic         exp_none;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl [NV];

    initial begin
        // req, mask, en, rdy | valid, idx, pend, none  (expected after the edge)
        tbl[0]  = '{16'h4208, 16'h0000, 1'b1, 1'b1, 1'b0, 4'd0,  16'h4208, 1'b0};
        tbl[1]  = '{16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 4'd14, 16'h0208, 1'b0};
        tbl[2]  = '{16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 4'd9,  16'h0008, 1'b0};
        tbl[3]  = '{16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 4'd3,  16'h0000, 1'b1};
        tbl[4]  = '{16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 4'd3,  16'h0000, 1'b1};
        tbl[5]  = '{16'h0200, 16'h0000, 1'b1, 1'b1, 1'b0, 4'd3,  16'h0200, 1'b0};
        tbl[6]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 4'd9,  16'h0000, 1'b1};
        tbl[7]  = '{16'h1000, 16'h0000, 1'b1, 1'b0, 1'b1, 4'd9,  16'h1000, 1'b0};
        tbl[8]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 4'd9,  16'h1000, 1'b0};
        tbl[9]  = '{16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 4'd12, 16'h0000, 1'b1};
        tbl[10] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 4'd12, 16'h0000, 1'b1};
        tbl[11] = '{16'h4004, 16'h4000, 1'b1, 1'b1, 1'b0, 4'd12, 16'h4004, 1'b0};
        tbl[12] = '{16'h0000, 16'h4000, 1'b1, 1'b1, 1'b1, 4'd2,  16'h4000, 1'b1};
        tbl[13] = '{16'h0000, 16'h4000, 1'b1, 1'b1, 1'b0, 4'd2,  16'h4000, 1'b1};
        tbl[14] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 4'd14, 16'h0000, 1'b1};
        tbl[15] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 4'd14, 16'h0000, 1'b1};
        tbl[16] = '{16'h0080, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd14, 16'h0080, 1'b0};
        tbl[17] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd14, 16'h0080, 1'b0};
        tbl[18] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 4'd7,  16'h0000, 1'b1};
        tbl[19] = '{16'h0040, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd7,  16'h0040, 1'b0};
        tbl[20] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd7,  16'h0040, 1'b0};
        tbl[21] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 4'd6,  16'h0000, 1'b1};
        tbl[22] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 4'd6,  16'h0000, 1'b1};

        model_reset();

        // --- reset held with all requests asserted ---
        req_i = '1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t1_rst.pend",  64'(pend_o),  64'(0));
            check("t1_rst.valid", 64'(valid_o), 64'(0));
            check("t1_rst.none",  64'(none_o),  64'(1));
            compare("t1_rst");
        end
        rst_n = 1'b1;
        apply('1, '0, 1'b1, 1'b1);
        check("t1_pend_ffff", 64'(pend_o),  64'(16'hffff));
        check("t1_valid0",    64'(valid_o), 64'(0));
        for (int c = 0; c < 20; c++) apply('0, '0, 1'b1, 1'b1);
        check("t1_drained", 64'(pend_o), 64'(0));
        $display("reset/drain sequence done");

        // --- directed table ---
        do_reset();
        for (int v = 0; v < NV; v++) begin
            apply(tbl[v].req, tbl[v].mask, tbl[v].en, tbl[v].rdy);
            $display("row %0d: req=%h mask=%h en=%b rdy=%b -> valid=%b idx=%0d pend=%h none=%b",
                     v, tbl[v].req, tbl[v].mask, tbl[v].en, tbl[v].rdy,
                     valid_o, idx_o, pend_o, none_o);
            check($sformatf("row%0d.valid", v), 64'(valid_o), 64'(tbl[v].exp_valid));
            check($sformatf("row%0d.idx", v),   64'(idx_o),   64'(tbl[v].exp_idx));
            check($sformatf("row%0d.pend", v),  64'(pend_o),  64'(tbl[v].exp_pend));
            check($sformatf("row%0d.none", v),  64'(none_o),  64'(tbl[v].exp_none));
        end

        // --- overflow counting and saturation on a masked line ---
        do_reset();
        apply(16'h0020, 16'h0020, 1'b1, 1'b1);
        for (int c = 0; c < 3; c++) begin
            apply(16'h0020, 16'h0020, 1'b1, 1'b1);
            apply(16'h0000, 16'h0020, 1'b1, 1'b1);
        end
        check("t5_ovf3", 64'(ovf_cnt_o), 64'(3));
        check("t5_pend5", 64'(pend_o), 64'(16'h0020));
        $display("overflow after 3 hits: %0d", ovf_cnt_o);
        for (int c = 0; c < 300; c++) apply(16'h0020, 16'h0020, 1'b1, 1'b1);
        check("t5_ovf_sat", 64'(ovf_cnt_o), 64'(255));
        $display("overflow after 303 hits: %0d", ovf_cnt_o);
        apply('0, '0, 1'b1, 1'b1);
        check("t5_issue5", 64'(idx_o), 64'(5));
        apply('0, '0, 1'b1, 1'b1);

        // --- level requests on {15,7} ---
        do_reset();
        apply(16'h8080, '0, 1'b1, 1'b1);
        check("t6_valid0", 64'(valid_o), 64'(0));
        for (int c = 0; c < 4; c++) begin
            int exp_i;
`ifdef ROUND_ROBIN_EN
            exp_i = (c % 2 == 0) ? 15 : 7;
`else
            exp_i = 15;
`endif
            apply(16'h8080, '0, 1'b1, 1'b1);
            $display("t6 grant %0d: idx=%0d valid=%b", c, idx_o, valid_o);
            check($sformatf("t6_grant%0d", c), 64'(idx_o), 64'(exp_i));
            check($sformatf("t6_valid%0d", c), 64'(valid_o), 64'(1));
        end
        for (int c = 0; c < 4; c++) apply('0, '0, 1'b1, 1'b1);

        // --- randomized traffic against the model, with a mid-run reset ---
        for (int c = 0; c < 2000; c++) begin
            logic [N-1:0] r;
            logic [N-1:0] m;
            r = N'($urandom) & N'($urandom) & N'($urandom);
            m = N'($urandom) & N'($urandom);
            if (c == 1000) do_reset();
            apply(r, m, ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0));
        end
        $display("random phase done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
